systolic_mac_grid: RTL and testbench

//  Parametrised ROWS x COLS output-stationary systolic array of DW-bit processing elements (PEs).

---
 rtl/systolic_mac_grid.sv | 183 ++++++++++++++++++
 tb/tb_systolic_mac_grid.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mac_grid.sv
// Output-stationary ROWS x COLS systolic grid of DW-bit PEs with run-time ALU mode
// (wrap MAC, saturating MAC, max-plus, pass-through), streamed load and row-major readout.
module systolic_mac_grid #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic [ROWS*DW-1:0]   a_in,
  input  logic [COLS*DW-1:0]   b_in,
  output logic                 in_ready,
  output logic                 busy,
  output logic                 out_valid,
  output logic [ACC_W-1:0]     out_data,
  output logic                 out_last,
  input  logic                 rd_en
);

  localparam int NW    = ROWS * COLS;
  localparam int CNT_W = $clog2(ROWS + COLS + 1);
  localparam int IDX_W = $clog2(NW + 1);

  localparam logic [1:0] M_WRAP = 2'b00;
  localparam logic [1:0] M_SAT  = 2'b01;
  localparam logic [1:0] M_TROP = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_FLUSH = 2'b10,
    S_DRAIN = 2'b11
  } state_t;

  if (ACC_W < 2 * DW) begin : g_bad_acc_w
    $error("systolic_mac_grid: ACC_W must be >= 2*DW");
  end

  // Handshake rule: a load beat transfers on an ena cycle with in_ready && in_valid;
  // a result word transfers on an ena cycle with out_valid && rd_en.

  state_t                 state_q;
  state_t                 state_d;
  logic [1:0]             mode_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [IDX_W-1:0]       idx_q;
  logic [ACC_W-1:0]       acc_q [NW];
  logic                   inject;
  logic                   clear;

  assign inject    = (state_q == S_LOAD) && in_valid;
  assign clear     = (state_q == S_IDLE) && start;
  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DRAIN);
  assign out_last  = (state_q == S_DRAIN) && (idx_q == IDX_W'(NW - 1));

  function automatic logic [ACC_W-1:0] pe_op(
    input logic [1:0]       m,
    input logic [ACC_W-1:0] acc,
    input logic [DW-1:0]    a,
    input logic [DW-1:0]    b
  );
    logic [ACC_W-1:0] prod;
    logic [ACC_W:0]   sum;
    logic [DW:0]      ab;
    prod = ACC_W'(a) * ACC_W'(b);
    sum  = {1'b0, acc} + {1'b0, prod};
    ab   = {1'b0, a} + {1'b0, b};
    case (m)
      M_WRAP:  pe_op = sum[ACC_W-1:0];
      M_SAT:   pe_op = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
      M_TROP:  pe_op = (ACC_W'(ab) > acc) ? ACC_W'(ab) : acc;
      default: pe_op = ACC_W'(a);
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  if (in_valid && in_last) state_d = S_FLUSH;
      S_FLUSH: if (cnt_q == CNT_W'(ROWS + COLS - 1)) state_d = S_DRAIN;
      S_DRAIN: if (rd_en && out_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 2'b00;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else if (ena) begin
      state_q <= state_d;
      if (clear) mode_q <= mode;
      if (state_q == S_FLUSH) cnt_q <= cnt_q + CNT_W'(1);
      else                    cnt_q <= '0;
      if (state_q != S_DRAIN || (rd_en && out_last)) idx_q <= '0;
      else if (rd_en)                                idx_q <= idx_q + IDX_W'(1);
    end
  end

  // Row r chain: first r stages are the skew, the next COLS stages feed PE(r,0..COLS-1).
  for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
    localparam int LEN = gr + COLS;
    logic [DW-1:0] a_ch [LEN];
    logic          v_ch [LEN];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < LEN; k++) begin
          a_ch[k] <= '0;
          v_ch[k] <= 1'b0;
        end
      end else if (ena) begin
        a_ch[0] <= a_in[gr*DW +: DW];
        v_ch[0] <= inject;
        for (int k = 1; k < LEN; k++) begin
          a_ch[k] <= a_ch[k-1];
          v_ch[k] <= v_ch[k-1];
        end
      end
    end
  end

  for (genvar gc = 0; gc < COLS; gc++) begin : g_col
    localparam int LEN = gc + ROWS;
    logic [DW-1:0] b_ch [LEN];
    logic          v_ch [LEN];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < LEN; k++) begin
          b_ch[k] <= '0;
          v_ch[k] <= 1'b0;
        end
      end else if (ena) begin
        b_ch[0] <= b_in[gc*DW +: DW];
        v_ch[0] <= inject;
        for (int k = 1; k < LEN; k++) begin
          b_ch[k] <= b_ch[k-1];
          v_ch[k] <= v_ch[k-1];
        end
      end
    end
  end

  // Both operands of a beat reach PE(r,c) after r+c+1 registers, so the pair is aligned.
  for (genvar gr = 0; gr < ROWS; gr++) begin : g_pe_row
    for (genvar gc = 0; gc < COLS; gc++) begin : g_pe
      logic          pair_valid;
      logic [DW-1:0] a_op;
      logic [DW-1:0] b_op;
      assign pair_valid = g_row[gr].v_ch[gr+gc] && g_col[gc].v_ch[gc+gr];
      assign a_op       = g_row[gr].a_ch[gr+gc];
      assign b_op       = g_col[gc].b_ch[gc+gr];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_q[gr*COLS+gc] <= '0;
        end else if (ena) begin
          if (clear)           acc_q[gr*COLS+gc] <= '0;
          else if (pair_valid) acc_q[gr*COLS+gc] <= pe_op(mode_q, acc_q[gr*COLS+gc], a_op, b_op);
        end
      end
    end
  end

  always_comb begin
    out_data = '0;
    if (state_q == S_DRAIN) begin
      for (int i = 0; i < NW; i++) begin
        if (idx_q == IDX_W'(i)) out_data = acc_q[i];
      end
    end
  end

endmodule

// File: tb/tb_systolic_mac_grid.sv
// Table-driven bench for systolic_mac_grid (4x4, 8-bit operands, 16-bit accumulators).
module tb_systolic_mac_grid;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int DW    = 8;
  localparam int ACC_W = 16;
  localparam int NW    = ROWS * COLS;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 ena = 1'b1;
  logic                 start = 1'b0;
  logic [1:0]           mode = 2'b00;
  logic                 in_valid = 1'b0;
  logic                 in_last = 1'b0;
  logic [ROWS*DW-1:0]   a_in = '0;
  logic [COLS*DW-1:0]   b_in = '0;
  logic                 in_ready;
  logic                 busy;
  logic                 out_valid;
  logic [ACC_W-1:0]     out_data;
  logic                 out_last;
  logic                 rd_en = 1'b0;

  systolic_mac_grid #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .mode(mode),
    .in_valid(in_valid), .in_last(in_last), .a_in(a_in), .b_in(b_in),
    .in_ready(in_ready), .busy(busy), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .rd_en(rd_en)
  );

  // clock / reset
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n++;

  int checks = 0;
  int errors = 0;

  typedef logic [4:0][31:0] beats_t;
  typedef struct packed {
    logic [1:0]  mode;
    logic [2:0]  ncyc;
    logic [4:0]  vmask;
    logic        rd_alt;
    logic        junk_start;
    logic        start_in_load;
    logic [2:0]  gap;
    beats_t      a;
    beats_t      b;
    logic [15:0] exp_w0;
    logic [15:0] exp_w15;
  } vec_t;

  vec_t tv [8];
  logic [ACC_W-1:0] exp_q [$];

  function automatic beats_t mk5(input logic [31:0] x0, input logic [31:0] x1,
                                 input logic [31:0] x2, input logic [31:0] x3,
                                 input logic [31:0] x4);
    mk5 = {x4, x3, x2, x1, x0};
  endfunction

  function automatic logic [31:0] rep4(input logic [7:0] v);
    rep4 = {v, v, v, v};
  endfunction

  // Reference model: fold each valid beat into one element, arithmetic done in 32-bit ints.
  function automatic logic [15:0] model_word(input vec_t v, input int r, input int c);
    int acc;
    int av;
    int bv;
    logic [31:0] wa;
    logic [31:0] wb;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      if (k < int'(v.ncyc) && v.vmask[k]) begin
        wa = v.a[k];
        wb = v.b[k];
        av = int'(wa[r*8 +: 8]);
        bv = int'(wb[c*8 +: 8]);
        case (v.mode)
          2'b00: acc = (acc + av * bv) % 65536;
          2'b01: acc = (acc + av * bv > 65535) ? 65535 : acc + av * bv;
          2'b10: acc = (av + bv > acc) ? av + bv : acc;
          default: acc = av;
        endcase
      end
    end
    model_word = acc[15:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: one complete job; abort_after >= 0 stops the drain after that many accepted words
  task automatic run_job(input vec_t v, input int abort_after);
    int t_last;
    int n;
    int cyc;
    int widx;
    mode     = v.mode;
    start    = 1'b1;
    if (v.junk_start) begin
      in_valid = 1'b1;
      in_last  = 1'b1;
      a_in     = rep4(8'd200);
      b_in     = rep4(8'd200);
    end
    step();
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("in_ready_load", in_ready, 1);
    t_last = 0;
    for (int k = 0; k < int'(v.ncyc); k++) begin
      start    = 1'b0;
      in_valid = v.vmask[k];
      in_last  = (k == int'(v.ncyc) - 1);
      a_in     = v.a[k];
      b_in     = v.b[k];
      if (v.start_in_load && k == 0) begin
        start = 1'b1;
        mode  = 2'b11;
      end
      step();
      t_last = edge_n;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("in_ready_flush", in_ready, 0);
    check("busy_flush", busy, 1);
    if (v.gap != 3'd0) begin
      step();
      step();
      ena = 1'b0;
      repeat (int'(v.gap)) step();
      ena = 1'b1;
    end
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    if (!out_valid) begin
      check("out_valid_timeout", 0, 1);
      return;
    end
    check("latency", edge_n - t_last, ROWS + COLS + int'(v.gap));

    // scoreboard: expected words in row-major order
    exp_q.delete();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        exp_q.push_back(model_word(v, r, c));

    cyc  = 0;
    widx = 0;
    while (exp_q.size() > 0 && cyc < 100) begin
      if (abort_after >= 0 && widx == abort_after) break;
      rd_en = v.rd_alt ? (cyc % 2 == 0) : 1'b1;
      check("out_valid_drain", out_valid, 1);
      check("word_data", out_data, exp_q[0]);
      check("out_last", out_last, (exp_q.size() == 1));
      if (rd_en) begin
        if (widx == 0)  check("hand_word0", out_data, v.exp_w0);
        if (widx == 15) check("hand_word15", out_data, v.exp_w15);
        void'(exp_q.pop_front());
        widx++;
      end
      step();
      cyc++;
    end
    rd_en = 1'b0;
    if (abort_after < 0) begin
      check("drain_complete", exp_q.size(), 0);
      check("busy_after", busy, 0);
      check("out_valid_after", out_valid, 0);
    end
  endtask

  initial begin
    // V0: WRAP single beat, per-lane operands; junk beat alongside start must be dropped
    tv[0] = '{mode: 2'b00, ncyc: 3'd1, vmask: 5'b00001, rd_alt: 1'b0, junk_start: 1'b1,
              start_in_load: 1'b0, gap: 3'd0,
              a: mk5(32'h04030201, 0, 0, 0, 0), b: mk5(32'h08070605, 0, 0, 0, 0),
              exp_w0: 16'd5, exp_w15: 16'd32};
    // V1/V2: 255*255 twice, wrapping vs saturating
    tv[1] = '{mode: 2'b00, ncyc: 3'd2, vmask: 5'b00011, rd_alt: 1'b0, junk_start: 1'b0,
              start_in_load: 1'b0, gap: 3'd0,
              a: mk5(rep4(8'hFF), rep4(8'hFF), 0, 0, 0), b: mk5(rep4(8'hFF), rep4(8'hFF), 0, 0, 0),
              exp_w0: 16'd64514, exp_w15: 16'd64514};
    tv[2] = tv[1];
    tv[2].mode = 2'b01;
    tv[2].exp_w0 = 16'd65535;
    tv[2].exp_w15 = 16'd65535;
    // V3/V4: max-plus then pass-through on (3,4),(10,1),(2,2)
    tv[3] = '{mode: 2'b10, ncyc: 3'd3, vmask: 5'b00111, rd_alt: 1'b0, junk_start: 1'b0,
              start_in_load: 1'b0, gap: 3'd0,
              a: mk5(rep4(8'd3), rep4(8'd10), rep4(8'd2), 0, 0),
              b: mk5(rep4(8'd4), rep4(8'd1), rep4(8'd2), 0, 0),
              exp_w0: 16'd11, exp_w15: 16'd11};
    tv[4] = tv[3];
    tv[4].mode = 2'b11;
    tv[4].exp_w0 = 16'd2;
    tv[4].exp_w15 = 16'd2;
    // V5: bubbles 1,0,0,1,1 carrying junk operands, alternating rd_en; 1*2+3*4+5*6 = 44
    tv[5] = '{mode: 2'b00, ncyc: 3'd5, vmask: 5'b11001, rd_alt: 1'b1, junk_start: 1'b0,
              start_in_load: 1'b0, gap: 3'd0,
              a: mk5(rep4(8'd1), rep4(8'h63), rep4(8'h63), rep4(8'd3), rep4(8'd5)),
              b: mk5(rep4(8'd2), rep4(8'h63), rep4(8'h63), rep4(8'd4), rep4(8'd6)),
              exp_w0: 16'd44, exp_w15: 16'd44};
    // V6: same beats contiguous, with a PASS start pulse in LOAD that must be ignored
    tv[6] = '{mode: 2'b00, ncyc: 3'd3, vmask: 5'b00111, rd_alt: 1'b0, junk_start: 1'b0,
              start_in_load: 1'b1, gap: 3'd0,
              a: mk5(rep4(8'd1), rep4(8'd3), rep4(8'd5), 0, 0),
              b: mk5(rep4(8'd2), rep4(8'd4), rep4(8'd6), 0, 0),
              exp_w0: 16'd44, exp_w15: 16'd44};
    // V7: V1 with ena low for 5 cycles during FLUSH
    tv[7] = tv[1];
    tv[7].gap = 3'd5;

    // reset state
    step();
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) run_job(tv[i], -1);

    // asynchronous reset in the middle of DRAIN, between clock edges
    run_job(tv[1], 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_job(tv[0], -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
